// File: rtl/warp_barrier_ctrl.sv
// Per-core warp barrier manager: parks arriving warps per barrier ID, releases
// them on local completion, and hands global barriers to the cluster one at a time.
module warp_barrier_ctrl #(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_BARRIERS = 4,
  parameter int GSIZE_WIDTH  = 8,
  parameter int NW_WIDTH     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
  parameter int NB_WIDTH     = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   bar_valid,
  input  logic [NW_WIDTH-1:0]    bar_wid,
  input  logic [NB_WIDTH-1:0]    bar_id,
  input  logic                   bar_is_global,
  input  logic [GSIZE_WIDTH-1:0] bar_size_m1,
  input  logic                   bar_is_noop,
  input  logic [NUM_WARPS-1:0]   active_warps,
  output logic                   gbar_req_valid,
  output logic [NB_WIDTH-1:0]    gbar_req_id,
  output logic [GSIZE_WIDTH-1:0] gbar_req_size_m1,
  input  logic                   gbar_req_ready,
  input  logic                   gbar_rsp_valid,
  input  logic [NB_WIDTH-1:0]    gbar_rsp_id,
  output logic [NUM_WARPS-1:0]   stalls,
  output logic                   release_valid,
  output logic [NUM_WARPS-1:0]   release_mask,
  output logic                   err
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_e;

  state_e                 state_q, state_d;
  logic [NW_WIDTH-1:0]    count_q [NUM_BARRIERS];
  logic [NW_WIDTH-1:0]    count_d [NUM_BARRIERS];
  logic [NUM_WARPS-1:0]   mask_q  [NUM_BARRIERS];
  logic [NUM_WARPS-1:0]   mask_d  [NUM_BARRIERS];
  logic [GSIZE_WIDTH-1:0] gsize_q [NUM_BARRIERS];
  logic [GSIZE_WIDTH-1:0] gsize_d [NUM_BARRIERS];
  logic [NUM_BARRIERS-1:0] gflag_q, gflag_d;
  logic [NUM_WARPS-1:0]   stalls_q, stalls_d;
  logic [NUM_WARPS-1:0]   rel_mask_q, rel_mask_d;
  logic                   rel_valid_q, rel_valid_d;
  logic                   err_q, err_d;
  logic [NB_WIDTH-1:0]    pend_id_q, pend_id_d;
  logic [GSIZE_WIDTH-1:0] pend_size_q, pend_size_d;

  logic [NUM_BARRIERS-1:0] gdone;
  logic                    sel_found;
  logic [NB_WIDTH-1:0]     sel_id;
  logic [NUM_WARPS-1:0]    wid_bit;
  logic [NW_WIDTH-1:0]     loc_size;
  logic [NUM_WARPS-1:0]    parked;
  logic [NUM_WARPS-1:0]    loc_mask, glb_mask;
  logic                    loc_rel, glb_rel;

  assign wid_bit  = NUM_WARPS'(1) << bar_wid;
  assign loc_size = bar_size_m1[NW_WIDTH-1:0];

  // A global barrier is locally complete once every active warp is parked on it.
  always_comb begin
    for (int i = 0; i < NUM_BARRIERS; i++) begin
      gdone[i] = gflag_q[i] && ((mask_q[i] & active_warps) == active_warps) &&
                 (mask_q[i] != '0);
    end
  end

  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    for (int i = NUM_BARRIERS - 1; i >= 0; i--) begin
      if (gdone[i]) begin
        sel_found = 1'b1;
        sel_id    = NB_WIDTH'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    mask_d      = mask_q;
    gsize_d     = gsize_q;
    gflag_d     = gflag_q;
    stalls_d    = stalls_q;
    err_d       = err_q;
    pend_id_d   = pend_id_q;
    pend_size_d = pend_size_q;
    loc_rel     = 1'b0;
    loc_mask    = '0;
    glb_rel     = 1'b0;
    glb_mask    = '0;
    parked      = '0;

    case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          pend_id_d   = sel_id;
          pend_size_d = gsize_q[sel_id];
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        if (gbar_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (gbar_rsp_valid) begin
          if (gbar_rsp_id == pend_id_q) begin
            glb_rel            = 1'b1;
            glb_mask           = mask_q[pend_id_q];
            mask_d[pend_id_q]  = '0;
            gflag_d[pend_id_q] = 1'b0;
            stalls_d           = stalls_d & ~glb_mask;
            state_d            = ST_IDLE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Requests see the post-release masks, so a same-cycle arrival starts a fresh barrier.
    for (int i = 0; i < NUM_BARRIERS; i++) parked = parked | mask_d[i];

    if (bar_valid && !bar_is_noop) begin
      if ((parked & wid_bit) != '0) begin
        err_d = 1'b1;
      end else if (bar_is_global) begin
        mask_d[bar_id]  = mask_d[bar_id] | wid_bit;
        gflag_d[bar_id] = 1'b1;
        gsize_d[bar_id] = bar_size_m1;
        stalls_d        = stalls_d | wid_bit;
      end else if (loc_size == '0) begin
        loc_rel  = 1'b1;
        loc_mask = wid_bit;
      end else if (count_d[bar_id] == loc_size) begin
        loc_rel         = 1'b1;
        loc_mask        = mask_d[bar_id] | wid_bit;
        count_d[bar_id] = '0;
        mask_d[bar_id]  = '0;
        stalls_d        = stalls_d & ~loc_mask;
      end else begin
        count_d[bar_id] = count_d[bar_id] + NW_WIDTH'(1);
        mask_d[bar_id]  = mask_d[bar_id] | wid_bit;
        stalls_d        = stalls_d | wid_bit;
      end
    end

    rel_valid_d = loc_rel | glb_rel;
    rel_mask_d  = loc_mask | glb_mask;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      for (int i = 0; i < NUM_BARRIERS; i++) begin
        count_q[i] <= '0;
        mask_q[i]  <= '0;
        gsize_q[i] <= '0;
      end
      gflag_q     <= '0;
      stalls_q    <= '0;
      rel_mask_q  <= '0;
      rel_valid_q <= 1'b0;
      err_q       <= 1'b0;
      pend_id_q   <= '0;
      pend_size_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      mask_q      <= mask_d;
      gsize_q     <= gsize_d;
      gflag_q     <= gflag_d;
      stalls_q    <= stalls_d;
      rel_mask_q  <= rel_mask_d;
      rel_valid_q <= rel_valid_d;
      err_q       <= err_d;
      pend_id_q   <= pend_id_d;
      pend_size_q <= pend_size_d;
    end
  end

  assign gbar_req_valid   = (state_q == ST_REQ);
  assign gbar_req_id      = pend_id_q;
  assign gbar_req_size_m1 = pend_size_q;
  assign stalls           = stalls_q;
  assign release_valid    = rel_valid_q;
  assign release_mask     = rel_mask_q;
  assign err              = err_q;

endmodule

// File: tb/tb_warp_barrier_ctrl.sv
// Bench for warp_barrier_ctrl: directed scenarios followed by randomized traffic,
// all checked against a warp-level reference model.
module tb_warp_barrier_ctrl;

  localparam int NW = 4;
  localparam int NB = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       bar_valid = 1'b0;
  logic [1:0] bar_wid = '0;
  logic [1:0] bar_id = '0;
  logic       bar_is_global = 1'b0;
  logic [7:0] bar_size_m1 = '0;
  logic       bar_is_noop = 1'b0;
  logic [3:0] active_warps = 4'hF;
  logic       gbar_req_valid;
  logic [1:0] gbar_req_id;
  logic [7:0] gbar_req_size_m1;
  logic       gbar_req_ready = 1'b0;
  logic       gbar_rsp_valid = 1'b0;
  logic [1:0] gbar_rsp_id = '0;
  logic [3:0] stalls;
  logic       release_valid;
  logic [3:0] release_mask;
  logic       err;

  int errors = 0;
  int checks = 0;

  // Reference model: where each warp is parked (-1 = running) plus the cluster handshake phase.
  int   parkedAt [NW];
  bit   mGlobal  [NB];
  int   mGsize   [NB];
  int   mPhase;
  int   mCur;
  int   mCurSize;
  bit   mErr;
  bit   mRelValid;
  logic [3:0] mRelMask;
  int   lsize [2];

  warp_barrier_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .bar_valid(bar_valid), .bar_wid(bar_wid), .bar_id(bar_id),
    .bar_is_global(bar_is_global), .bar_size_m1(bar_size_m1), .bar_is_noop(bar_is_noop),
    .active_warps(active_warps),
    .gbar_req_valid(gbar_req_valid), .gbar_req_id(gbar_req_id),
    .gbar_req_size_m1(gbar_req_size_m1), .gbar_req_ready(gbar_req_ready),
    .gbar_rsp_valid(gbar_rsp_valid), .gbar_rsp_id(gbar_rsp_id),
    .stalls(stalls), .release_valid(release_valid), .release_mask(release_mask),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int w = 0; w < NW; w++) parkedAt[w] = -1;
    for (int b = 0; b < NB; b++) begin
      mGlobal[b] = 1'b0;
      mGsize[b]  = 0;
    end
    mPhase = 0; mCur = 0; mCurSize = 0; mErr = 1'b0;
    mRelValid = 1'b0; mRelMask = '0;
  endtask

  function automatic int warpsAt(input int b);
    int n = 0;
    for (int w = 0; w < NW; w++) if (parkedAt[w] == b) n++;
    return n;
  endfunction

  function automatic bit allActiveAt(input int b);
    for (int w = 0; w < NW; w++) if (active_warps[w] && parkedAt[w] != b) return 1'b0;
    return warpsAt(b) > 0;
  endfunction

  task automatic releaseAt(input int b);
    for (int w = 0; w < NW; w++) begin
      if (parkedAt[w] == b) begin
        parkedAt[w] = -1;
        mRelMask[w] = 1'b1;
      end
    end
    mRelValid = 1'b1;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic modelEdge();
    bit found;
    int w, b, n;
    mRelValid = 1'b0;
    mRelMask  = '0;
    if (!reset_n) begin
      modelReset();
      return;
    end
    if (mPhase == 0) begin
      found = 1'b0;
      for (int i = 0; i < NB; i++) begin
        if (!found && mGlobal[i] && allActiveAt(i)) begin
          found = 1'b1; mCur = i; mCurSize = mGsize[i]; mPhase = 1;
        end
      end
    end else if (mPhase == 1) begin
      if (gbar_req_ready) mPhase = 2;
    end else if (gbar_rsp_valid) begin
      if (int'(gbar_rsp_id) == mCur) begin
        releaseAt(mCur);
        mGlobal[mCur] = 1'b0;
        mPhase = 0;
      end else begin
        mErr = 1'b1;
      end
    end
    if (bar_valid && !bar_is_noop) begin
      w = int'(bar_wid);
      b = int'(bar_id);
      if (parkedAt[w] != -1) begin
        mErr = 1'b1;
      end else if (bar_is_global) begin
        parkedAt[w] = b; mGlobal[b] = 1'b1; mGsize[b] = int'(bar_size_m1);
      end else begin
        n = int'(bar_size_m1) % NW;
        if (n == 0) begin
          mRelValid = 1'b1; mRelMask[w] = 1'b1;
        end else if (warpsAt(b) == n) begin
          parkedAt[w] = b;
          releaseAt(b);
        end else begin
          parkedAt[w] = b;
        end
      end
    end
  endtask

  task automatic compareAll();
    logic [3:0] expStalls = '0;
    for (int w = 0; w < NW; w++) if (parkedAt[w] != -1) expStalls[w] = 1'b1;
    checkOutput("stalls", 32'(stalls), 32'(expStalls));
    checkOutput("release_valid", 32'(release_valid), 32'(mRelValid));
    checkOutput("release_mask", 32'(release_mask), 32'(mRelMask));
    checkOutput("gbar_req_valid", 32'(gbar_req_valid), 32'(mPhase == 1));
    if (mPhase == 1) begin
      checkOutput("gbar_req_id", 32'(gbar_req_id), 32'(mCur));
      checkOutput("gbar_req_size", 32'(gbar_req_size_m1), 32'(mCurSize));
    end
    checkOutput("err", 32'(err), 32'(mErr));
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    #1;
    compareAll();
  endtask

  task automatic applyStimulus(input bit v, input int w, input int id, input bit g,
                               input int size, input bit noop);
    bar_valid     = v;
    bar_wid       = 2'(w);
    bar_id        = 2'(id);
    bar_is_global = g;
    bar_size_m1   = 8'(size);
    bar_is_noop   = noop;
  endtask

  task automatic setCluster(input bit rdy, input bit rv, input int rid);
    gbar_req_ready = rdy;
    gbar_rsp_valid = rv;
    gbar_rsp_id    = 2'(rid);
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, 0, 0, 0);
    setCluster(0, 0, 0);
    reset_n = 1'b0;
    modelReset();
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic randomStep();
    int freeQ[$];
    int id;
    for (int w = 0; w < NW; w++) if (parkedAt[w] == -1) freeQ.push_back(w);
    if (freeQ.size() > 0 && $urandom_range(0, 1) == 1) begin
      id = $urandom_range(0, 3);
      applyStimulus(1, freeQ[$urandom_range(0, freeQ.size() - 1)], id, id >= 2,
                    (id >= 2) ? $urandom_range(0, 255) : lsize[id],
                    $urandom_range(0, 7) == 0);
    end else begin
      applyStimulus(0, 0, 0, 0, 0, 0);
    end
    setCluster($urandom_range(0, 1) == 1, (mPhase == 2) && ($urandom_range(0, 2) == 0), mCur);
  endtask

  initial begin
    modelReset();
    tick();
    doReset();
    tick();
    checkOutput("reset_stalls", 32'(stalls), 32'h0);
    checkOutput("reset_req_valid", 32'(gbar_req_valid), 32'h0);
    checkOutput("reset_err", 32'(err), 32'h0);

    // Local three-warp barrier on id 1.
    applyStimulus(1, 0, 1, 0, 2, 0); tick();
    checkOutput("loc_stall0", 32'(stalls), 32'b0001);
    applyStimulus(1, 2, 1, 0, 2, 0); tick();
    checkOutput("loc_stall02", 32'(stalls), 32'b0101);
    applyStimulus(1, 3, 1, 0, 2, 0); tick();
    checkOutput("loc_rel_valid", 32'(release_valid), 32'h1);
    checkOutput("loc_rel_mask", 32'(release_mask), 32'b1101);
    checkOutput("loc_rel_stalls", 32'(stalls), 32'h0);
    applyStimulus(1, 0, 1, 0, 1, 0); tick();
    checkOutput("loc_count_cleared", 32'(release_valid), 32'h0);
    applyStimulus(1, 1, 1, 0, 1, 0); tick();
    checkOutput("loc_rel2_mask", 32'(release_mask), 32'b0011);

    // Trivial barrier and noop.
    applyStimulus(1, 2, 0, 0, 0, 0); tick();
    checkOutput("triv_mask", 32'(release_mask), 32'b0100);
    checkOutput("triv_stalls", 32'(stalls), 32'h0);
    applyStimulus(1, 1, 0, 0, 2, 1); tick();
    checkOutput("noop_rel", 32'(release_valid), 32'h0);
    checkOutput("noop_stalls", 32'(stalls), 32'h0);

    // Global barrier id 2 with a stalled handshake.
    for (int w = 0; w < NW; w++) begin
      applyStimulus(1, w, 2, 1, 3, 0); tick();
    end
    checkOutput("glb_all_stalled", 32'(stalls), 32'hF);
    applyStimulus(0, 0, 0, 0, 0, 0); tick();
    checkOutput("glb_req_valid", 32'(gbar_req_valid), 32'h1);
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput("glb_hold_valid", 32'(gbar_req_valid), 32'h1);
      checkOutput("glb_hold_id", 32'(gbar_req_id), 32'd2);
      checkOutput("glb_hold_size", 32'(gbar_req_size_m1), 32'd3);
    end
    setCluster(1, 0, 0); tick();
    checkOutput("glb_accepted", 32'(gbar_req_valid), 32'h0);
    setCluster(0, 1, 2); tick();
    checkOutput("glb_rel_mask", 32'(release_mask), 32'hF);
    setCluster(0, 0, 0); tick();

    // Two global barriers completing together: lower id goes first.
    applyStimulus(1, 0, 3, 1, 5, 0); tick();
    applyStimulus(1, 1, 3, 1, 5, 0); tick();
    applyStimulus(1, 2, 0, 1, 1, 0); tick();
    applyStimulus(1, 3, 0, 1, 1, 0); tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    active_warps = 4'b0000; tick();
    checkOutput("two_first_id", 32'(gbar_req_id), 32'd0);
    setCluster(1, 0, 0); tick();
    setCluster(0, 1, 0); tick();
    checkOutput("two_rel0", 32'(release_mask), 32'b1100);
    checkOutput("two_id3_stalled", 32'(stalls), 32'b0011);
    setCluster(0, 0, 0); tick();
    checkOutput("two_second_id", 32'(gbar_req_id), 32'd3);
    setCluster(1, 0, 0); tick();
    setCluster(0, 1, 3); tick();
    checkOutput("two_rel3", 32'(release_mask), 32'b0011);
    setCluster(0, 0, 0);
    active_warps = 4'hF; tick();

    // Re-arrival of a parked warp.
    applyStimulus(1, 1, 0, 0, 2, 0); tick();
    applyStimulus(1, 1, 0, 0, 2, 0); tick();
    checkOutput("rearrive_err", 32'(err), 32'h1);
    applyStimulus(1, 0, 0, 0, 2, 0); tick();
    checkOutput("rearrive_no_count", 32'(release_valid), 32'h0);
    applyStimulus(1, 2, 0, 0, 2, 0); tick();
    checkOutput("rearrive_rel", 32'(release_mask), 32'b0111);

    // Mismatched response id while waiting.
    doReset();
    for (int w = 0; w < NW; w++) begin
      applyStimulus(1, w, 1, 1, 2, 0); tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 0); tick();
    setCluster(1, 0, 0); tick();
    setCluster(0, 1, 3); tick();
    checkOutput("mismatch_err", 32'(err), 32'h1);
    checkOutput("mismatch_no_rel", 32'(release_valid), 32'h0);
    setCluster(0, 1, 1); tick();
    checkOutput("mismatch_still_wait", 32'(release_mask), 32'hF);
    setCluster(0, 0, 0); tick();

    // Asynchronous reset while a request is outstanding.
    for (int w = 0; w < NW; w++) begin
      applyStimulus(1, w, 2, 1, 7, 0); tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 0); tick();
    checkOutput("prereset_req", 32'(gbar_req_valid), 32'h1);
    reset_n = 1'b0;
    modelReset();
    #1;
    checkOutput("async_req_drop", 32'(gbar_req_valid), 32'h0);
    checkOutput("async_stalls", 32'(stalls), 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    checkOutput("postreset_err", 32'(err), 32'h0);

    // Randomized traffic in reset-separated segments.
    for (int seg = 0; seg < 12; seg++) begin
      doReset();
      active_warps = 4'($urandom_range(1, 15));
      lsize[0] = $urandom_range(0, 3);
      lsize[1] = $urandom_range(0, 3);
      for (int c = 0; c < 60; c++) begin
        randomStep();
        tick();
      end
    end

    $display("[TB] directed and random phases complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/warp_barrier_ctrl.md
Name: warp_barrier_ctrl

Overview:
- Per-core barrier manager fed by the issue/SFU warp-control path with barrier requests (valid, id, is_global, size_m1, is_noop).
- Tracks arrivals per barrier ID and stalls arrived warps. Releases them when the local count completes.
- For global barriers, it hands off to the cluster-level barrier over a valid/ready request plus a response strobe.
- Its stall mask is consumed by the warp scheduler.

Parameters:
- NUM_WARPS, 4, warps per core.
- NUM_BARRIERS, 4, barrier IDs per core; NB_WIDTH = max(1, clog2(NUM_BARRIERS)).
- NW_WIDTH, max(1, clog2(NUM_WARPS)), warp-id width; also the local size_m1 width.
- GSIZE_WIDTH, 8, width of the global size_m1.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- bar_valid  in  1  barrier request strobe, one per cycle, always accepted.
- bar_wid  in  NW_WIDTH  requesting warp.
- bar_id  in  NB_WIDTH  barrier ID.
- bar_is_global  in  1  global barrier.
- bar_size_m1  in  GSIZE_WIDTH  local: warps-1 (low NW_WIDTH bits used); global: cores-1.
- bar_is_noop  in  1  request carries no barrier action.
- active_warps  in  NUM_WARPS  currently active warps (global local-phase target).
- gbar_req_valid  out  1  global barrier request.
- gbar_req_id  out  NB_WIDTH  ID sent to cluster.
- gbar_req_size_m1  out  GSIZE_WIDTH  cores-1.
- gbar_req_ready  in  1  cluster accepts request.
- gbar_rsp_valid  in  1  cluster release strobe.
- gbar_rsp_id  in  NB_WIDTH  released ID.
- stalls  out  NUM_WARPS  warps currently parked at a barrier.
- release_valid  out  1  one-cycle release pulse.
- release_mask  out  NUM_WARPS  warps released this cycle.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (async, reset_n=0): all count[b]=0, mask[b]=0, gsize[b]=0, gflag[b]=0, stalls=0, release_valid=0, release_mask=0, gbar_req_valid=0, err=0, FSM=IDLE.
- Request handling:
  - noop: bar_valid with is_noop=1 causes no state change.
  - Local, size_m1==0: next cycle release_valid=1 and release_mask=(1<<wid); the warp is never stalled.
  - Local, count[id]==size_m1[NW_WIDTH-1:0]: next cycle release_valid=1 and release_mask=mask[id]|(1<<wid). count, mask and stalls bits clear in the same edge.
  - Local, otherwise: count[id]++, mask[id]|=(1<<wid), stalls[wid] set next cycle.
- Global request: mask[id]|=(1<<wid), stalls[wid]=1, gflag[id]=1, gsize[id]=size_m1.
- Global local-complete condition: gflag[b] && (mask[b] & active_warps)==active_warps && mask[b]!=0.
- Error: a request from a warp already set in any mask[*] leaves all state unchanged and sets err=1. err clears only on reset.
- Mixing local and global on one ID is a protocol violation; behaviour is undefined and not checked.
- Global FSM:
  - IDLE: select the lowest-index complete barrier b; load id/size_m1; go REQ.
  - REQ: gbar_req_valid=1; id and size are held stable until gbar_req_ready. On the valid&&ready cycle go WAIT.
  - WAIT: on gbar_rsp_valid with gbar_rsp_id==pending id, next cycle release mask[b]. Clear mask[b] and gflag[b], clear those stalls bits, go IDLE.
  - WAIT: gbar_rsp_valid with a mismatched ID sets err and is ignored.
  - Only one global barrier is in flight. Other completed global IDs wait in IDLE selection; their warps stay stalled.
- Simultaneous local and global release in one cycle: release_mask is the OR of both (disjoint warps), with a single pulse.
- Latency:
  - Arrival to stall: 1 cycle.
  - Final local arrival to release: 1 cycle.
  - gbar_rsp to release: 1 cycle.
  - Completion to gbar_req_valid: 1 cycle after entering IDLE-select.
- A request arriving in the same cycle as a release of the same ID is applied after the clear: it counts as the first arrival.
- Counters are NW_WIDTH wide and cannot overflow, since count ≤ size_m1 < NUM_WARPS.
- Reset mid-operation (REQ or WAIT) drops gbar_req_valid asynchronously and discards all pending barriers.

Test Plan:
- Local 3-warp barrier: id=1, size_m1=2; warps 0,2 arrive on cycles 0,1 -> stalls=4'b0101. Warp 3 arrives on cycle 2 -> cycle 3 release_valid=1, release_mask=4'b1101, stalls=0, count[1]=0.
- Trivial and noop: size_m1=0 from wid=2 -> next cycle release_mask=4'b0100, stalls stays 0. is_noop=1 request -> no change on any output.
- Global, active_warps=4'b1111: all 4 warps hit id=2 with size_m1=3 -> gbar_req_valid=1, id=2, size=3.
  - Hold gbar_req_ready=0 for 5 cycles -> fields stable.
  - Ready then gbar_rsp id=2 -> release_mask=4'b1111 one cycle later.
- Two global completions, ids 3 and 0 complete the same cycle -> id 0 requested first. Id 3 is requested after id 0's response, and its warps stay stalled meanwhile.
- Errors: warp 1 re-arrives at id=0 while parked -> err=1, count unchanged. Mismatched gbar_rsp_id in WAIT -> err=1, FSM stays WAIT.
- Reset: reset_n low during REQ -> gbar_req_valid=0 immediately, and stalls=0 and err=0 after release of reset.
